// File: rtl/delay_timer.sv
// Restartable, prescaled delay timer: a rising trigger edge starts a count of N ticks
// of PRESCALE clocks each, ending in a one-cycle time_out pulse (one-shot or auto-reload).
module delay_timer #(
  parameter int WIDTH    = 14,
  parameter int PRESCALE = 50000,
  localparam int PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic             cancel,
  input  logic             mode,
  input  logic [WIDTH-1:0] N,
  output logic             time_out,
  output logic             busy,
  output logic [WIDTH-1:0] count_out
);

  typedef enum logic {
    IDLE     = 1'b0,
    COUNTING = 1'b1
  } state_e;

  localparam logic [PW-1:0]    PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);

  state_e             state_q;
  logic               trig_q;
  logic               mode_lat_q;
  logic [WIDTH-1:0]   n_lat_q;
  logic [WIDTH-1:0]   count_q;
  logic [PW-1:0]      presc_q;
  logic               time_out_q;

  logic               start;
  logic               tick;
  logic               n_zero;

  assign start  = trigger & ~trig_q;
  assign tick   = (state_q == COUNTING) && (presc_q == '0);
  assign n_zero = (N == '0);

  // Single-process FSM: priority is cancel > start > tick > prescaler decrement.
  // A cancel swallows a coincident start, but trig_q still tracks the trigger
  // so a held level cannot restart the timer once the cancel is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      trig_q     <= 1'b0;
      mode_lat_q <= 1'b0;
      n_lat_q    <= '0;
      count_q    <= '0;
      presc_q    <= '0;
      time_out_q <= 1'b0;
    end else begin
      trig_q     <= trigger;
      time_out_q <= 1'b0;
      if (cancel) begin
        if (state_q == COUNTING) begin
          state_q <= IDLE;
          count_q <= '0;
          presc_q <= '0;
        end
      end else if (start) begin
        if (!n_zero) begin
          state_q    <= COUNTING;
          n_lat_q    <= N;
          mode_lat_q <= mode;
          count_q    <= N;
          presc_q    <= PRESC_MAX;
        end else begin
          // Zero-length delay: expire immediately, abandoning any count in flight.
          state_q    <= IDLE;
          count_q    <= '0;
          presc_q    <= '0;
          time_out_q <= 1'b1;
        end
      end else if (tick) begin
        if (count_q > CNT_ONE) begin
          count_q <= count_q - CNT_ONE;
          presc_q <= PRESC_MAX;
        end else if (count_q == CNT_ONE) begin
          time_out_q <= 1'b1;
          if (mode_lat_q) begin
            count_q <= n_lat_q;
            presc_q <= PRESC_MAX;
          end else begin
            state_q <= IDLE;
            count_q <= '0;
            presc_q <= '0;
          end
        end
      end else if ((state_q == COUNTING) && (presc_q != '0)) begin
        presc_q <= presc_q - PW'(1);
      end
    end
  end

  assign time_out  = time_out_q;
  assign busy      = (state_q == COUNTING);
  assign count_out = count_q;

endmodule

// File: tb/tb_delay_timer.sv
// Directed bench for delay_timer at WIDTH=8, PRESCALE=4; expected values are hand-derived
// per cycle relative to the edge E0 that samples the start.
module tb_delay_timer;

  localparam int WIDTH    = 8;
  localparam int PRESCALE = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             trigger;
  logic             cancel;
  logic             mode;
  logic [WIDTH-1:0] n_in;
  logic             time_out;
  logic             busy;
  logic [WIDTH-1:0] count_out;

  int checks = 0;
  int errors = 0;

  delay_timer #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .clk       (clk),
    .rst       (rst),
    .trigger   (trigger),
    .cancel    (cancel),
    .mode      (mode),
    .N         (n_in),
    .time_out  (time_out),
    .busy      (busy),
    .count_out (count_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, act, exp);
    end
  endtask

  // Advance one active edge and settle 1 ns past it for driving and sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int exp_to, input int exp_busy, input int exp_cnt);
    check({tag, " time_out"}, {31'd0, time_out}, exp_to);
    check({tag, " busy"}, {31'd0, busy}, exp_busy);
    check({tag, " count"}, {24'd0, count_out}, exp_cnt);
  endtask

  initial begin
    rst = 1'b1; trigger = 1'b0; cancel = 1'b0; mode = 1'b0; n_in = '0;
    step(); step();
    check_all("reset", 0, 0, 0);
    rst = 1'b0;
    step();
    check_all("idle", 0, 0, 0);

    // 1: one-shot N=3, pulse 12 cycles after E0
    n_in = 8'd3; mode = 1'b0; trigger = 1'b1;
    step();
    trigger = 1'b0;
    check_all("t1 k0", 0, 1, 3);
    for (int k = 1; k <= 14; k++) begin
      step();
      check_all($sformatf("t1 k%0d", k), (k == 12) ? 1 : 0, (k < 12) ? 1 : 0,
                (k < 12) ? 3 - k / 4 : 0);
    end

    // 2: periodic N=2, pulses every 8, cancel sampled at E0+26
    n_in = 8'd2; mode = 1'b1; trigger = 1'b1;
    step();
    trigger = 1'b0;
    check_all("t2 k0", 0, 1, 2);
    for (int k = 1; k <= 25; k++) begin
      step();
      check_all($sformatf("t2 k%0d", k), (k % 8 == 0) ? 1 : 0, 1, (k % 8 < 4) ? 2 : 1);
    end
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check_all("t2 cancel", 0, 0, 0);
    for (int k = 27; k <= 34; k++) begin
      step();
      check_all($sformatf("t2 k%0d", k), 0, 0, 0);
    end

    // 3: N=1 with trigger held high for 40 cycles
    n_in = 8'd1; mode = 1'b0; trigger = 1'b1;
    step();
    check_all("t3 k0", 0, 1, 1);
    for (int k = 1; k <= 40; k++) begin
      step();
      check_all($sformatf("t3 k%0d", k), (k == 4) ? 1 : 0, (k < 4) ? 1 : 0, (k < 4) ? 1 : 0);
    end
    trigger = 1'b0;
    step();

    // 4: N=3 start, restart with N=5 at E0+5
    n_in = 8'd3; trigger = 1'b1;
    step();
    trigger = 1'b0;
    check_all("t4 k0", 0, 1, 3);
    for (int k = 1; k <= 30; k++) begin
      if (k == 5) begin
        n_in = 8'd5; trigger = 1'b1;
      end
      step();
      if (k == 5) trigger = 1'b0;
      if (k < 5)
        check_all($sformatf("t4 k%0d", k), 0, 1, (k < 4) ? 3 : 2);
      else
        check_all($sformatf("t4 k%0d", k), (k == 25) ? 1 : 0, (k < 25) ? 1 : 0,
                  (k < 25) ? 5 - (k - 5) / 4 : 0);
    end

    // 5: N=0 gives an immediate pulse; cancel with start is a no-op
    n_in = 8'd0; trigger = 1'b1;
    step();
    trigger = 1'b0;
    check_all("t5 zero k0", 1, 0, 0);
    step();
    check_all("t5 zero k1", 0, 0, 0);
    n_in = 8'd3; trigger = 1'b1; cancel = 1'b1;
    step();
    cancel = 1'b0;
    check_all("t5 cancel+start", 0, 0, 0);
    for (int k = 1; k <= 15; k++) begin
      step();
      check_all($sformatf("t5 held k%0d", k), 0, 0, 0);
    end
    trigger = 1'b0;
    step();

    // 6: reset sampled at E0+6 during an N=3 count
    n_in = 8'd3; trigger = 1'b1;
    step();
    trigger = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check_all($sformatf("t6 k%0d", k), 0, 1, (k < 4) ? 3 : 2);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all("t6 rst", 0, 0, 0);
    for (int k = 7; k <= 20; k++) begin
      step();
      check_all($sformatf("t6 k%0d", k), 0, 0, 0);
    end

    // Trigger already high on the first cycle after reset counts as a start
    rst = 1'b1; n_in = 8'd1; trigger = 1'b1;
    step(); step();
    check_all("t7 in reset", 0, 0, 0);
    rst = 1'b0;
    step();
    check_all("t7 k0", 0, 1, 1);
    for (int k = 1; k <= 6; k++) begin
      step();
      check_all($sformatf("t7 k%0d", k), (k == 4) ? 1 : 0, (k < 4) ? 1 : 0, (k < 4) ? 1 : 0);
    end
    trigger = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
